// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial digit adder: FSM encoding and the
// helpers that size the step counter from WIDTH and DIGIT.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step configuration still needs a one-bit counter.
  function automatic int cnt_width_f(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder. c_msb is the carry into the
// top bit, used by the parent to form signed overflow on the last digit.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic [DIGIT:0] c;
    // NOTE: every output gets a default first so no path can infer a latch.
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[DIGIT];
    c_msb = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock over
// WIDTH/DIGIT cycles behind a start/busy/done handshake.
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = steps_f(WIDTH, DIGIT);
  localparam int CW    = cnt_width_f(STEPS);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
  logic             carry;

  logic             accept, last;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(STEPS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  // New digit enters at the top so after STEPS shifts the LSB digit is at bit 0.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working shift registers are cleared too, so nothing from an
      // aborted operation lingers; it costs only a reset mux per bit.
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      acc   <= acc_next;
      carry <= dcout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= acc_next;
        cout <= dcout;
        ovf  <= dcmsb ^ dcout;
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench: directed WIDTH=8/DIGIT=2 vectors plus an exhaustive
// WIDTH=4 sweep at DIGIT 1, 2 and 4 running alongside.
module tb_serial_digit_adder;

  localparam int STEPS = 4;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    time        t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       s_rst;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t m_e;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int w, input int ia, input int ib, input logic icin,
                                input logic isub, output logic [7:0] s, output logic co,
                                output logic ov);
    int mask, bb, c, full, sa, sb, ss;
    mask = (1 << w) - 1;
    bb   = isub ? (~ib & mask) : ib;
    c    = isub ? 1 : int'(icin);
    full = ia + bb + c;
    s    = 8'(full & mask);
    co   = ((full >> w) & 1) != 0;
    sa   = (ia >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    ss   = (int'(s) >> (w - 1)) & 1;
    ov   = (sa == sb) && (ss != sa);
  endfunction

  // Main monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("busy_low_in_done", busy, 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: sum=0x%0h at t=%0t", sum, $time);
      end else begin
        m_e = q.pop_front();
        check("sum", sum, m_e.sum);
        check("cout", cout, m_e.cout);
        check("ovf", ovf, m_e.ovf);
        check("latency", 32'($time), 32'(m_e.t));
      end
    end
  end

  // Called at a negedge; the accept edge is the following posedge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic isub, input logic push, input logic [7:0] es,
                       input logic ec, input logic eo);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(posedge clk);
    if (push) q.push_back('{sum: es, cout: ec, ovf: eo, t: $time + STEPS * 10 + 5});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d required=0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    s_rst = 1'b1;
    repeat (3) @(negedge clk);
    s_rst = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SD = 1 << g;
    localparam int SS = 4 / SD;

    logic       start_s, sub_s, cin_s, busy_s, done_s, cout_s, ovf_s;
    logic [3:0] a_s, b_s, sum_s;
    bit         fin;
    exp_t       sq[$];
    exp_t       se;

    serial_digit_adder #(.WIDTH(4), .DIGIT(SD)) u_dut (
      .clk(clk), .rst(s_rst), .start(start_s), .sub(sub_s), .a(a_s), .b(b_s), .cin(cin_s),
      .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s)
    );

    always @(negedge clk) begin
      if (!s_rst && done_s) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sweep_unexpected_done: digit=%0d at t=%0t", SD, $time);
        end else begin
          se = sq.pop_front();
          check($sformatf("sweep%0d_sum", SD), 32'(sum_s), se.sum);
          check($sformatf("sweep%0d_cout", SD), cout_s, se.cout);
          check($sformatf("sweep%0d_ovf", SD), ovf_s, se.ovf);
          check($sformatf("sweep%0d_latency", SD), 32'($time), 32'(se.t));
        end
      end
    end

    initial begin
      logic [7:0] es;
      logic       ec, eo;
      int         k;
      fin = 1'b0; start_s = 1'b0; sub_s = 1'b0; cin_s = 1'b0; a_s = '0; b_s = '0;
      repeat (4) @(negedge clk);
      for (int v = 0; v < 1024; v++) begin
        a_s = v[3:0]; b_s = v[7:4]; cin_s = v[8]; sub_s = v[9]; start_s = 1'b1;
        model(4, int'(a_s), int'(b_s), cin_s, sub_s, es, ec, eo);
        @(posedge clk);
        sq.push_back('{sum: es, cout: ec, ovf: eo, t: $time + SS * 10 + 5});
        @(negedge clk);
        start_s = 1'b0;
        k = 0;
        while (!done_s && k < 20) begin
          @(negedge clk);
          k++;
        end
        if (!done_s) begin
          total++;
          bad++;
          $display("FAIL sweep_timeout: digit=%0d vector=%0d", SD, v);
        end
      end
      repeat (4) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int  k;
    bit  seen;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Reset mid-RUN discards the operation.
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_sum", sum, 8'h00);

    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    check("busy_after_accept", busy, 1);
    wait_drain();
    issue(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0); wait_drain();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1); wait_drain();
    issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); wait_drain();
    issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1); wait_drain();
    issue(8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); wait_drain();

    // start during RUN must be ignored.
    issue(8'h33, 8'h11, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);
    check("sum_hold_idle", sum, 8'h44);

    // Back-to-back: second start issued in the DONE cycle.
    issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_done_seen", done, 1);
    issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    check("b2b_busy", busy, 1);
    check("b2b_hold_early", sum, 8'h03);
    repeat (3) @(negedge clk);
    check("b2b_hold_late", sum, 8'h03);
    wait_drain();
    check("b2b_final_sum", sum, 8'h30);

    k = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin)) begin
      total++;
      bad++;
      $display("FAIL sweep_not_finished: waited=%0d cycles", k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's 2-bit combinational full adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, over WIDTH/DIGIT cycles, using a start/busy/done handshake. Carry-out and signed overflow are registered. It sits in datapaths where a narrow adder must be time-shared across wide operands.

## Interface
- WIDTH, 8: operand and result width; must be a multiple of DIGIT.
- DIGIT, 2: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when accepting (IDLE or DONE).
- sub  in  1  0 = a + b + cin; 1 = a − b, computed as a + ~b + 1, with cin ignored.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; latched on accept.
- cin  in  1  carry in; latched on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is valid.
- sum  out  WIDTH  result; held until the next accept.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- STEPS = WIDTH/DIGIT.
- FSM has three states: IDLE, RUN, DONE.
- Reset (any state, including mid-RUN) sets: state to IDLE; busy, done, cout and ovf to 0; sum to 0; step counter to 0. Any in-flight operation is discarded.
- IDLE: start=1 → latch a and b (b inverted if sub), set carry to (sub ? 1 : cin), set counter to 0, go to RUN.
- RUN: each cycle, add the low DIGIT bits of the A and B shift registers with the carry register.
  - The result digit shifts into the top of the result register; the operands shift right by DIGIT.
  - The carry register takes the digit carry.
  - The counter increments.
  - start is ignored throughout RUN.
- On the cycle the counter reaches STEPS−1: set cout to the digit carry and ovf to (carry into bit WIDTH−1) XOR (digit carry), then go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → accept a new operation as from IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- sum, cout and ovf change only on a RUN→DONE transition or on reset; they stay stable through IDLE.
- Intermediate shifting happens in an internal register. The sum port is updated only at completion.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Accept at edge k. RUN occupies edges k+1 … k+STEPS. DONE is visible in the cycle after edge k+STEPS.
- Latency from start sampled to done high: STEPS+1 edges.
- Throughput with back-to-back starts: one result per STEPS+1 cycles.
- busy and done are never high together. busy rises the cycle after accept.
- Operands may change freely after the accept edge.

## Structure
- Shared package serial_adder_pkg holds:
  - the state typedef and encoding (IDLE=0, RUN=1, DONE=2);
  - a function computing STEPS and the counter width, $clog2(STEPS) with a minimum of 1.
- Sub-module digit_adder is a combinational DIGIT-bit ripple of full adders.
  - Ports: a, b, cin, sum, cout, plus c_msb (carry into the top bit), which is used for ovf.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
All scenarios use WIDTH=8, DIGIT=2, so STEPS=4.
- Reset: hold rst for 2 cycles → busy=0, done=0, sum=0x00, cout=0, ovf=0. Assert rst mid-RUN → IDLE next cycle, done never pulses, sum unchanged at its reset value.
- Add: a=0x0F, b=0x01, cin=0, start → busy high for 4 cycles, then done for 1 cycle with sum=0x10, cout=0, ovf=0.
- Carry and overflow:
  - a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0 → sum=0x80, ovf=1.
- Subtract:
  - sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0 (borrow), ovf=0.
  - sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
  - sub=1, a=0x05, b=0x07, cin=1 → cin has no effect, sum=0xFE.
- Handshake:
  - start pulsed during RUN with different operands → ignored; the result matches the original operands.
  - start=1 in the DONE cycle (a=0x10, b=0x20) → busy the next cycle, second done 5 cycles later with sum=0x30; the first result is held until that point.
- Sweep: exhaustive a, b, cin, sub at WIDTH=4 with DIGIT ∈ {1,2,4} → every result matches the reference model; latency is always STEPS+1.
